one_dim_convol_ctrl: RTL and testbench
======================================

# one_dim_convol_ctrl

Line sequencer and coefficient manager for the one-dimensional convolution kernel. It accepts samples over a valid/ready handshake and forwards exactly `LINE_LENGTH` of them per line to the kernel. It then appends `WINDOW_SIZE-1` zero samples to flush the window, and counts kernel output strobes until the full `LINE_LENGTH+WINDOW_SIZE-1` results are out. Coefficients are double-buffered: software writes a shadow bank at any time, and the shadow bank is copied into the active bank only at a line start. The kernel therefore never sees coefficients change mid-line.

## Interface
Parameters:
- `DATA_SIZE`, `settings_pkg` value (16): sample and coefficient width.
- `WINDOW_SIZE`, `settings_pkg` value (8): number of taps.
- `LINE_LENGTH`, 256: samples per line; must be ≥ 1.
- `KERNEL_LATENCY`, 8: kernel input-enable to output-valid latency in cycles; sets the drain timeout.

Ports:
- `clk`  in  1  — single clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request a line; honoured only in IDLE.
- `coeff_wr_en`  in  1  — shadow-bank write strobe.
- `coeff_wr_addr`  in  `$clog2(WINDOW_SIZE)`  — shadow tap index.
- `coeff_wr_data`  in  `DATA_SIZE`  — shadow tap value.
- `coeff_commit`  in  1  — pulse that marks the shadow bank for copy at the next line start.
- `in_data`  in  `DATA_SIZE`  — sample.
- `in_valid`  in  1  — sample valid.
- `in_ready`  out  1  — high only in RUN.
- `kernel_data`  out  `DATA_SIZE`  — registered sample to the kernel.
- `kernel_enable`  out  1  — registered sample strobe to the kernel.
- `kernel_coeff`  out  `DATA_SIZE` × `WINDOW_SIZE`  — active bank, driven directly from registers.
- `kernel_out_valid`  in  1  — kernel `output_data_valid`.
- `busy`  out  1  — state ≠ IDLE.
- `line_done`  out  1  — one-cycle pulse at line completion.
- `error`  out  1  — sticky error flag; cleared by an accepted `start`.

## Operation
- Reset values: all outputs 0. Both banks 0. Commit-pending flag 0. All counters 0. State is IDLE.
- IDLE: `start`=1 moves to LOAD and clears `error`, the sample counter and the output counter.
- LOAD: lasts 1 cycle.
  - If commit-pending is set, copy shadow to active and clear the flag.
  - A `coeff_commit` arriving in the same cycle leaves the flag set.
  - A shadow write in the same cycle is not part of the copy; it lands in the shadow bank only.
  - Always moves to RUN.
- RUN: each `in_valid && in_ready` registers `in_data` into `kernel_data` and sets `kernel_enable`=1 for one cycle; otherwise `kernel_enable`=0. The accept with sample count `LINE_LENGTH-1` moves to FLUSH.
- FLUSH: drives `kernel_data`=0 with `kernel_enable`=1 for exactly `WINDOW_SIZE-1` consecutive cycles, then moves to DRAIN. With `WINDOW_SIZE`=1, FLUSH is skipped.
- Output counting: every `kernel_out_valid` in LOAD, RUN, FLUSH or DRAIN increments the output counter. When the counter reaches `LINE_LENGTH+WINDOW_SIZE-1`, pulse `line_done` and go to IDLE.
- Drain timeout: in DRAIN, `2*KERNEL_LATENCY` cycles with no `kernel_out_valid` set `error` and return to IDLE without `line_done`.
- `start` outside IDLE is ignored and sets `error`.
- Extra `kernel_out_valid` in IDLE is ignored.
- Shadow writes are legal in every state.
- `reset_n` low mid-line aborts immediately to reset values; no `line_done` is produced.

## Timing
- `start` sampled at edge T: LOAD during T..T+1; RUN from T+2, and `in_ready`=1 from T+2.
- Sample accepted at edge t: `kernel_enable`/`kernel_data` are valid in the cycle after t.
- `in_ready` is a state decode (registered state). It drops the cycle after the last accept, so there are no extra accepts.
- The first FLUSH zero immediately follows the last real sample's `kernel_enable`, with no gap.
- `line_done` and `busy`→0 occur in the cycle after the final counted `kernel_out_valid`.
- Minimum line time, with `in_valid` held high: 2 + `LINE_LENGTH` + (`WINDOW_SIZE-1`) + `KERNEL_LATENCY` cycles.
- `start` is accepted again from the cycle `busy`=0.

## Structure
- `settings_pkg` additions: `LINE_LENGTH` default and the `ctrl_state_t` enum {IDLE, LOAD, RUN, FLUSH, DRAIN}.
- Sub-module `one_dim_convol_coeff_bank`: shadow and active register arrays, the write port, the commit-pending flag and the copy strobe.
- The FSM, the counters and the kernel drive registers live in the top module.

## Test plan
All scenarios use `WINDOW_SIZE`=4, `LINE_LENGTH`=8, `KERNEL_LATENCY`=8, and a kernel model with an 8-cycle delayed valid.
- Coefficients written 1,2,3,4 plus commit, then `start`, then samples 1..8 → `kernel_coeff`={1,2,3,4} from T+2. `kernel_enable` shows 8 samples followed by 3 zeros. 11 outputs are counted, `line_done` pulses once and `error`=0.
- `in_valid` toggling 1,0,1,0 → exactly 8 accepts. `kernel_enable` mirrors the accepts one cycle later. `in_ready`=0 after the 8th accept.
- Line in progress: shadow written to 9,9,9,9 with commit → `kernel_coeff` stays {1,2,3,4} until the next LOAD, then becomes {9,9,9,9}.
- `start` pulsed in RUN → `error`=1 and the line still completes normally. The next accepted `start` clears `error`.
- Kernel model drops the last 2 output valids → `error`=1 sixteen cycles after the last valid, then IDLE with no `line_done`.
- `reset_n` low during FLUSH → outputs and banks read 0 immediately. After release the block is in IDLE with `in_ready`=0.

Source files
------------

// File: rtl/one_dim_convol_ctrl_pkg.sv
// Shared settings for the 1-D convolution datapath: default sizes and the line controller state encoding.
package one_dim_convol_ctrl_pkg;
   localparam int DFLT_DATA_SIZE      = 16;
   localparam int DFLT_WINDOW_SIZE    = 8;
   localparam int DFLT_LINE_LENGTH    = 256;
   localparam int DFLT_KERNEL_LATENCY = 8;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DRAIN} ctrl_state_t;
endpackage

// File: rtl/one_dim_convol_ctrl_if.sv
// Sample input handshake plus the kernel-facing bus of the line controller.
interface one_dim_convol_ctrl_if
   import one_dim_convol_ctrl_pkg::*;
#(
   parameter int DATA_SIZE   = DFLT_DATA_SIZE,
   parameter int WINDOW_SIZE = DFLT_WINDOW_SIZE
) ();
   logic [DATA_SIZE-1:0]                  in_data;
   logic                                  in_valid;
   logic                                  in_ready;
   logic [DATA_SIZE-1:0]                  kernel_data;
   logic                                  kernel_enable;
   logic [WINDOW_SIZE-1:0][DATA_SIZE-1:0] kernel_coeff;
   logic                                  kernel_out_valid;

   modport master (
      input  in_data, in_valid, kernel_out_valid,
      output in_ready, kernel_data, kernel_enable, kernel_coeff
   );

   modport slave (
      output in_data, in_valid, kernel_out_valid,
      input  in_ready, kernel_data, kernel_enable, kernel_coeff
   );
endinterface

// File: rtl/one_dim_convol_coeff_bank.sv
// Double-buffered tap store: software writes the shadow bank at any time, and a pending
// commit copies shadow into the active bank only when the controller sits in LOAD.
module one_dim_convol_coeff_bank
   import one_dim_convol_ctrl_pkg::*;
#(
   parameter int DATA_SIZE   = DFLT_DATA_SIZE,
   parameter int WINDOW_SIZE = DFLT_WINDOW_SIZE,
   parameter int ADDR_W      = 3
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  wr_en,
   input  logic [ADDR_W-1:0]                     wr_addr,
   input  logic [DATA_SIZE-1:0]                  wr_data,
   input  logic                                  commit,
   input  logic                                  load,
   output logic [WINDOW_SIZE-1:0][DATA_SIZE-1:0] active
);
   typedef logic [WINDOW_SIZE-1:0][DATA_SIZE-1:0] bank_t;

   bank_t shadow_q, shadow_d;
   bank_t active_q, active_d;
   logic  pending_q, pending_d;
   logic  copy;

   assign copy = load && pending_q;

   // The copy reads shadow_q, so a write in the LOAD cycle lands in shadow only.
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en) begin
         shadow_d[wr_addr] = wr_data;
      end
      active_d  = copy ? shadow_q : active_q;
      pending_d = pending_q;
      if (copy) begin
         pending_d = 1'b0;
      end
      if (commit) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   assign active = active_q;
endmodule

// File: rtl/one_dim_convol_ctrl.sv
// Line sequencer: forwards LINE_LENGTH samples to the kernel, appends WINDOW_SIZE-1 zeros,
// then counts kernel outputs until the line is complete or the drain watchdog expires.
module one_dim_convol_ctrl
   import one_dim_convol_ctrl_pkg::*;
#(
   parameter int DATA_SIZE      = DFLT_DATA_SIZE,
   parameter int WINDOW_SIZE    = DFLT_WINDOW_SIZE,
   parameter int LINE_LENGTH    = DFLT_LINE_LENGTH,
   parameter int KERNEL_LATENCY = DFLT_KERNEL_LATENCY,
   localparam int ADDR_W        = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 coeff_wr_en,
   input  logic [ADDR_W-1:0]    coeff_wr_addr,
   input  logic [DATA_SIZE-1:0] coeff_wr_data,
   input  logic                 coeff_commit,
   one_dim_convol_ctrl_if.master kif,
   output logic                 busy,
   output logic                 line_done,
   output logic                 error
);
   localparam int TOTAL = LINE_LENGTH + WINDOW_SIZE - 1;
   localparam int SCW   = $clog2(LINE_LENGTH + 1);
   localparam int FCW   = $clog2(WINDOW_SIZE + 1);
   localparam int OCW   = $clog2(TOTAL + 1);
   localparam int TCW   = $clog2(2 * KERNEL_LATENCY + 1);

   localparam logic [SCW-1:0] SAMPLE_LAST  = SCW'(LINE_LENGTH - 1);
   localparam logic [FCW-1:0] FLUSH_LAST   = FCW'(WINDOW_SIZE - 2);
   localparam logic [OCW-1:0] OUT_LAST     = OCW'(TOTAL - 1);
   localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(2 * KERNEL_LATENCY - 1);

   ctrl_state_t          state_q, state_d;
   logic [SCW-1:0]       sample_cnt_q, sample_cnt_d;
   logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
   logic [OCW-1:0]       out_cnt_q, out_cnt_d;
   logic [TCW-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic [DATA_SIZE-1:0] kernel_data_q, kernel_data_d;
   logic                 kernel_enable_q, kernel_enable_d;
   logic                 line_done_q, line_done_d;
   logic                 error_q, error_d;

   logic accept, start_ok, counting, out_hit, timeout_hit;

   assign accept      = kif.in_valid && (state_q == RUN);
   assign start_ok    = start && (state_q == IDLE);
   assign counting    = (state_q != IDLE);
   assign out_hit     = counting && kif.kernel_out_valid && (out_cnt_q == OUT_LAST);
   assign timeout_hit = (state_q == DRAIN) && !kif.kernel_out_valid && (tmo_cnt_q == TIMEOUT_LAST);

   one_dim_convol_coeff_bank #(
      .DATA_SIZE   (DATA_SIZE),
      .WINDOW_SIZE (WINDOW_SIZE),
      .ADDR_W      (ADDR_W)
   ) u_coeff_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (coeff_wr_en),
      .wr_addr (coeff_wr_addr),
      .wr_data (coeff_wr_data),
      .commit  (coeff_commit),
      .load    (state_q == LOAD),
      .active  (kif.kernel_coeff)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    state_d = RUN;
         RUN:     if (accept && (sample_cnt_q == SAMPLE_LAST))
                     state_d = (WINDOW_SIZE > 1) ? FLUSH : DRAIN;
         FLUSH:   if (flush_cnt_q == FLUSH_LAST) state_d = DRAIN;
         DRAIN:   if (timeout_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Completion wins over every other transition, whatever phase the line is in.
      if (out_hit) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      kif.in_ready = (state_q == RUN);
      busy         = (state_q != IDLE);
   end

   always_comb begin
      sample_cnt_d    = sample_cnt_q;
      flush_cnt_d     = flush_cnt_q;
      out_cnt_d       = out_cnt_q;
      tmo_cnt_d       = '0;
      kernel_data_d   = kernel_data_q;
      kernel_enable_d = 1'b0;
      line_done_d     = out_hit;
      error_d         = error_q;

      if (start_ok) begin
         error_d      = 1'b0;
         sample_cnt_d = '0;
         flush_cnt_d  = '0;
         out_cnt_d    = '0;
      end
      if ((start && !start_ok) || timeout_hit) begin
         error_d = 1'b1;
      end
      if (accept) begin
         kernel_data_d   = kif.in_data;
         kernel_enable_d = 1'b1;
         sample_cnt_d    = sample_cnt_q + SCW'(1);
      end
      if (state_q == FLUSH) begin
         kernel_data_d   = '0;
         kernel_enable_d = 1'b1;
         flush_cnt_d     = flush_cnt_q + FCW'(1);
      end
      if (counting && kif.kernel_out_valid) begin
         out_cnt_d = out_cnt_q + OCW'(1);
      end
      if ((state_q == DRAIN) && !kif.kernel_out_valid) begin
         tmo_cnt_d = tmo_cnt_q + TCW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_cnt_q    <= '0;
         flush_cnt_q     <= '0;
         out_cnt_q       <= '0;
         tmo_cnt_q       <= '0;
         kernel_data_q   <= '0;
         kernel_enable_q <= 1'b0;
         line_done_q     <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         sample_cnt_q    <= sample_cnt_d;
         flush_cnt_q     <= flush_cnt_d;
         out_cnt_q       <= out_cnt_d;
         tmo_cnt_q       <= tmo_cnt_d;
         kernel_data_q   <= kernel_data_d;
         kernel_enable_q <= kernel_enable_d;
         line_done_q     <= line_done_d;
         error_q         <= error_d;
      end
   end

   assign kif.kernel_data   = kernel_data_q;
   assign kif.kernel_enable = kernel_enable_q;
   assign line_done         = line_done_q;
   assign error             = error_q;
endmodule

// File: tb/tb_one_dim_convol_ctrl.sv
// Line-level scenarios for the convolution line controller against a cycle model of the line rules.
module tb_one_dim_convol_ctrl;
   import one_dim_convol_ctrl_pkg::*;

   localparam int DW    = 16;
   localparam int WS    = 4;
   localparam int LL    = 8;
   localparam int KL    = 8;
   localparam int TOTAL = LL + WS - 1;

   typedef logic [WS-1:0][DW-1:0] bank_t;

   typedef struct {
      int    vmode;       // 0 valid held high, 1 toggling, 2 random
      bit    pre_wr;
      bank_t pre_c;
      bit    pre_commit;
      bit    load_wr;     // write tap0=11 and commit during the LOAD cycle
      bit    mid_wr;
      bank_t mid_c;
      bit    start_mid;
      bit    drop2;
      bit    idle_vld;
      bank_t exp_c;
      bit    exp_done;
      bit    exp_err;
   } line_vec_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          coeff_wr_en = 1'b0;
   logic [1:0]    coeff_wr_addr = '0;
   logic [DW-1:0] coeff_wr_data = '0;
   logic          coeff_commit = 1'b0;
   logic          busy, line_done, error;

   one_dim_convol_ctrl_if #(.DATA_SIZE(DW), .WINDOW_SIZE(WS)) kif ();

   one_dim_convol_ctrl #(
      .DATA_SIZE(DW), .WINDOW_SIZE(WS), .LINE_LENGTH(LL), .KERNEL_LATENCY(KL)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .coeff_wr_en   (coeff_wr_en),
      .coeff_wr_addr (coeff_wr_addr),
      .coeff_wr_data (coeff_wr_data),
      .coeff_commit  (coeff_commit),
      .kif           (kif),
      .busy          (busy),
      .line_done     (line_done),
      .error         (error)
   );

   always #5 clk = ~clk;

   // Kernel stand-in: output valid trails each enable by KL cycles; optionally loses the last two.
   logic [KL-1:0] vpipe;
   int            en_idx;
   bit            drop_mode = 1'b0;
   bit            extra_vld = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vpipe  <= '0;
         en_idx <= 0;
      end else begin
         vpipe <= {vpipe[KL-2:0], kif.kernel_enable && !(drop_mode && en_idx >= TOTAL - 2)};
         if (!busy) en_idx <= 0;
         else if (kif.kernel_enable) en_idx <= en_idx + 1;
      end
   end
   assign kif.kernel_out_valid = vpipe[KL-1] | extra_vld;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bank_t pk(input int a, input int b, input int c, input int d);
      bank_t r;
      r[0] = DW'(a); r[1] = DW'(b); r[2] = DW'(c); r[3] = DW'(d);
      return r;
   endfunction

   function automatic line_vec_t mk(input int vmode, input bit pre_wr, input bank_t pre_c,
                                    input bit pre_commit, input bit load_wr, input bit mid_wr,
                                    input bank_t mid_c, input bit start_mid, input bit drop2,
                                    input bit idle_vld, input bank_t exp_c, input bit exp_done,
                                    input bit exp_err);
      line_vec_t v;
      v.vmode = vmode; v.pre_wr = pre_wr; v.pre_c = pre_c; v.pre_commit = pre_commit;
      v.load_wr = load_wr; v.mid_wr = mid_wr; v.mid_c = mid_c; v.start_mid = start_mid;
      v.drop2 = drop2; v.idle_vld = idle_vld; v.exp_c = exp_c;
      v.exp_done = exp_done; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic run_line(input line_vec_t v);
      int            acc = 0;
      int            flush_left = 0;
      int            nval = 0;
      int            kv = -1000;
      int            ndone = 0;
      bit            exp_en = 1'b0;
      bit            done_due = 1'b0;
      bit            err_exp = 1'b0;
      bit            finished = 1'b0;
      bit            rdy_exp;
      logic [DW-1:0] exp_dat = '0;

      drop_mode = v.drop2;
      if (v.idle_vld) begin
         for (int i = 0; i < 3; i++) begin
            extra_vld = 1'b1;
            step();
            chk("idle_vld_busy", busy, 0);
         end
         extra_vld = 1'b0;
      end
      if (v.pre_wr) begin
         for (int i = 0; i < WS; i++) begin
            coeff_wr_en = 1'b1; coeff_wr_addr = 2'(i); coeff_wr_data = v.pre_c[i];
            step();
         end
         coeff_wr_en = 1'b0;
      end
      if (v.pre_commit) begin
         coeff_commit = 1'b1;
         step();
         coeff_commit = 1'b0;
      end
      start = 1'b1;
      step();
      start = 1'b0;

      for (int k = 0; k < 300; k++) begin
         rdy_exp = (k >= 1) && (acc < LL);
         if (line_done === 1'b1) ndone++;
         if (done_due) begin
            chk("done_pulse", line_done, 1);
            chk("done_busy", busy, 0);
            chk("done_error", error, err_exp);
            finished = 1'b1;
         end else if (v.drop2 && nval == TOTAL - 2 && k == kv + 2 * KL + 1) begin
            chk("timeout_error", error, 1);
            chk("timeout_busy", busy, 0);
            chk("timeout_no_done", line_done, 0);
            finished = 1'b1;
         end else begin
            chk("busy", busy, 1);
            chk("line_done_low", line_done, 0);
            chk("error", error, err_exp);
            chk("in_ready", kif.in_ready, rdy_exp);
            chk("kernel_enable", kif.kernel_enable, exp_en);
            if (exp_en) chk("kernel_data", kif.kernel_data, exp_dat);
            if (k >= 1) chk("kernel_coeff", kif.kernel_coeff, v.exp_c);
         end
         if (finished) break;

         if (kif.kernel_out_valid) begin
            nval++;
            kv = k;
            if (nval == TOTAL) done_due = 1'b1;
         end

         case (v.vmode)
            0:       kif.in_valid = 1'b1;
            1:       kif.in_valid = (k % 2 == 1);
            default: kif.in_valid = ($urandom_range(0, 3) != 0);
         endcase
         kif.in_data  = DW'($urandom);
         coeff_wr_en  = 1'b0;
         coeff_commit = 1'b0;
         start        = 1'b0;
         if (v.load_wr && k == 0) begin
            coeff_wr_en = 1'b1; coeff_wr_addr = 2'd0; coeff_wr_data = 16'd11; coeff_commit = 1'b1;
         end
         if (v.mid_wr && k >= 3 && k <= 6) begin
            coeff_wr_en = 1'b1; coeff_wr_addr = 2'(k - 3); coeff_wr_data = v.mid_c[k-3];
         end
         if (v.mid_wr && k == 7) coeff_commit = 1'b1;
         if (v.start_mid && k == 3) begin
            start   = 1'b1;
            err_exp = 1'b1;
         end

         if (kif.in_valid && rdy_exp) begin
            exp_en  = 1'b1;
            exp_dat = kif.in_data;
            acc++;
            if (acc == LL) flush_left = WS - 1;
         end else if (flush_left > 0) begin
            exp_en  = 1'b1;
            exp_dat = '0;
            flush_left--;
         end else begin
            exp_en = 1'b0;
         end
         step();
      end

      if (!finished) begin
         n_vec++;
         n_bad++;
         $display("FAIL line_end: line did not finish within 300 cycles (busy=%0b)", busy);
      end
      kif.in_valid = 1'b0; coeff_wr_en = 1'b0; coeff_commit = 1'b0; start = 1'b0;
      chk("line_done_count", ndone, v.exp_done);
      chk("end_error", error, v.exp_err);
      chk("valid_count", nval, v.drop2 ? TOTAL - 2 : TOTAL);
      step();
      chk("line_done_one_cycle", line_done, 0);
      drop_mode = 1'b0;
   endtask

   line_vec_t tbl[9];
   line_vec_t lv;
   bank_t     rc;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //        vmode pre pre_c            pcm ldw mid mid_c            smid drop idle exp_c               done err
      tbl[0] = mk(0, 1, pk(1, 2, 3, 4),     1,  0,  0,  '0,             0,   0,   0,   pk(1, 2, 3, 4),     1,   0);
      tbl[1] = mk(1, 0, '0,                 0,  0,  1,  pk(9, 9, 9, 9), 0,   0,   0,   pk(1, 2, 3, 4),     1,   0);
      tbl[2] = mk(2, 0, '0,                 0,  0,  0,  '0,             1,   0,   0,   pk(9, 9, 9, 9),     1,   1);
      tbl[3] = mk(0, 0, '0,                 0,  0,  0,  '0,             0,   0,   1,   pk(9, 9, 9, 9),     1,   0);
      tbl[4] = mk(0, 0, '0,                 0,  0,  0,  '0,             0,   1,   0,   pk(9, 9, 9, 9),     0,   1);
      tbl[5] = mk(2, 1, pk(5, 6, 7, 8),     0,  0,  0,  '0,             0,   0,   0,   pk(9, 9, 9, 9),     1,   0);
      tbl[6] = mk(1, 0, '0,                 1,  0,  0,  '0,             0,   0,   0,   pk(5, 6, 7, 8),     1,   0);
      tbl[7] = mk(0, 1, pk(20, 21, 22, 23), 1,  1,  0,  '0,             0,   0,   0,   pk(20, 21, 22, 23), 1,   0);
      tbl[8] = mk(2, 0, '0,                 0,  0,  0,  '0,             0,   0,   0,   pk(11, 21, 22, 23), 1,   0);

      kif.in_valid = 1'b0;
      kif.in_data  = '0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_line_done", line_done, 0);
      chk("rst_error", error, 0);
      chk("rst_in_ready", kif.in_ready, 0);
      chk("rst_kernel_enable", kif.kernel_enable, 0);
      chk("rst_kernel_data", kif.kernel_data, 0);
      chk("rst_kernel_coeff", kif.kernel_coeff, 0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 9; i++) run_line(tbl[i]);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < WS; i++) rc[i] = DW'($urandom);
         lv = mk(2, 1, rc, 1, 0, 0, '0, 0, 0, 0, rc, 1, 0);
         run_line(lv);
      end

      // Abort a line while it is flushing zeros into the kernel.
      start = 1'b1;
      step();
      start = 1'b0;
      kif.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) step();
      kif.in_valid = 1'b0;
      chk("flush_before_reset_enable", kif.kernel_enable, 1);
      chk("flush_before_reset_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("abort_kernel_enable", kif.kernel_enable, 0);
      chk("abort_kernel_data", kif.kernel_data, 0);
      chk("abort_kernel_coeff", kif.kernel_coeff, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", kif.in_ready, 0);
      chk("abort_line_done", line_done, 0);
      chk("abort_error", error, 0);
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("post_reset_busy", busy, 0);
      chk("post_reset_in_ready", kif.in_ready, 0);
      chk("post_reset_line_done", line_done, 0);

      // Shadow bank was cleared too: committing it yields all-zero taps.
      lv = mk(0, 0, '0, 1, 0, 0, '0, 0, 0, 0, '0, 1, 0);
      run_line(lv);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
